// File: rtl/tow_game_ctrl.sv
// Tug-of-war game sequencer: idle, start-flash countdown, live rope play, winner flash.
// Produces registered LED-mode select, one-hot rope position and winner flags for the LED mux.
`timescale 1ns/1ps
module tow_game_ctrl #(
    parameter int TICK_DIV      = 25000000,
    parameter int START_FLASHES = 3,
    parameter int WIN_FLASHES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    output logic [1:0] leds_ctrl,
    output logic [6:0] score,
    output logic [1:0] winner,
    output logic       busy
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HC_MAX = 2 * ((START_FLASHES > WIN_FLASHES) ? START_FLASHES : WIN_FLASHES);
    localparam int HC_W   = $clog2(HC_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [HC_W-1:0]  START_LAST = HC_W'(2 * START_FLASHES - 1);
    localparam logic [HC_W-1:0]  WIN_LAST   = HC_W'(2 * WIN_FLASHES - 1);

    localparam logic [2:0] POS_HOME  = 3'd3;
    localparam logic [2:0] POS_LEFT  = 3'd6;
    localparam logic [2:0] POS_RIGHT = 3'd0;

    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_IDLE  = 2'd1;
    localparam logic [1:0] LED_SCORE = 2'd2;
    localparam logic [1:0] LED_ALL   = 2'd3;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PLAY  = 2'd2,
        S_WIN   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [HC_W-1:0]  hc, hc_nxt;
    logic [2:0]       pos, pos_nxt;
    logic [1:0]       leds_nxt;
    logic [6:0]       score_nxt;
    logic [1:0]       winner_nxt;
    logic             busy_nxt;
    logic             prev_l, prev_r;
    logic             press_l, press_r, tick;

    function automatic logic [6:0] pos_to_score(input logic [2:0] p);
        pos_to_score = 7'b000_0001 << p;
    endfunction

    assign press_l = pb_l & ~prev_l;
    assign press_r = pb_r & ~prev_r;
    assign tick    = (cnt == CNT_LAST);

    // History flops reset high so a button held through reset release is not a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hc        <= '0;
            pos       <= POS_HOME;
            leds_ctrl <= LED_IDLE;
            score     <= pos_to_score(POS_HOME);
            winner    <= WIN_NONE;
            busy      <= 1'b0;
            prev_l    <= 1'b1;
            prev_r    <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hc        <= hc_nxt;
            pos       <= pos_nxt;
            leds_ctrl <= leds_nxt;
            score     <= score_nxt;
            winner    <= winner_nxt;
            busy      <= busy_nxt;
            prev_l    <= pb_l;
            prev_r    <= pb_r;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = tick ? '0 : cnt + 1'b1;
        hc_nxt     = hc;
        pos_nxt    = pos;
        leds_nxt   = leds_ctrl;
        score_nxt  = score;
        winner_nxt = winner;
        busy_nxt   = busy;

        case (state)
            S_IDLE: begin
                leds_nxt = LED_IDLE;
                busy_nxt = 1'b0;
                if (press_l || press_r) begin
                    state_nxt  = S_START;
                    winner_nxt = WIN_NONE;
                    busy_nxt   = 1'b1;
                    leds_nxt   = LED_ALL;
                    hc_nxt     = '0;
                    cnt_nxt    = '0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (hc == START_LAST) begin
                        state_nxt = S_PLAY;
                        leds_nxt  = LED_SCORE;
                        pos_nxt   = POS_HOME;
                        score_nxt = pos_to_score(POS_HOME);
                        cnt_nxt   = '0;
                    end else begin
                        leds_nxt = (leds_ctrl == LED_ALL) ? LED_OFF : LED_ALL;
                        hc_nxt   = hc + 1'b1;
                    end
                end
            end

            // Simultaneous presses cancel; the rope saturates into a win instead of wrapping
            S_PLAY: begin
                leds_nxt = LED_SCORE;
                if (press_l && !press_r) begin
                    if (pos == POS_LEFT) begin
                        state_nxt  = S_WIN;
                        winner_nxt = WIN_LEFT;
                        leds_nxt   = LED_ALL;
                        hc_nxt     = '0;
                        cnt_nxt    = '0;
                    end else begin
                        pos_nxt   = pos + 1'b1;
                        score_nxt = pos_to_score(pos + 1'b1);
                    end
                end else if (press_r && !press_l) begin
                    if (pos == POS_RIGHT) begin
                        state_nxt  = S_WIN;
                        winner_nxt = WIN_RIGHT;
                        leds_nxt   = LED_ALL;
                        hc_nxt     = '0;
                        cnt_nxt    = '0;
                    end else begin
                        pos_nxt   = pos - 1'b1;
                        score_nxt = pos_to_score(pos - 1'b1);
                    end
                end
            end

            S_WIN: begin
                if (tick) begin
                    if (hc == WIN_LAST) begin
                        state_nxt = S_IDLE;
                        leds_nxt  = LED_IDLE;
                        busy_nxt  = 1'b0;
                        pos_nxt   = POS_HOME;
                        score_nxt = pos_to_score(POS_HOME);
                        cnt_nxt   = '0;
                    end else begin
                        leds_nxt = (leds_ctrl == LED_ALL) ? LED_SCORE : LED_ALL;
                        hc_nxt   = hc + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
                leds_nxt  = LED_IDLE;
                busy_nxt  = 1'b0;
                pos_nxt   = POS_HOME;
                score_nxt = pos_to_score(POS_HOME);
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: doc/tow_game_ctrl.md
Name: tow_game_ctrl

Overview:
- Game-sequencing controller for the tug-of-war board.
- Watches the two player buttons and tracks the rope position.
- Drives the 2-bit LED-mode select and the 7-bit score pattern consumed by the LED multiplexer: idle pattern, start-flash countdown, live play, winner flash.
- Sits between the debounced button synchronisers and the LED mux.

Parameters:
- TICK_DIV, 25000000, clock cycles per flash half-period (must be ≥2).
- START_FLASHES, 3, number of full on/off flashes before play begins.
- WIN_FLASHES, 4, number of full on/score flashes after a win.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- pb_l  input  1  left player button, debounced, synchronous to clk, level
- pb_r  input  1  right player button, debounced, synchronous to clk, level
- leds_ctrl  output  2  LED mode select: 0 = off, 1 = idle pattern, 2 = score, 3 = all on
- score  output  7  one-hot rope position; bit 6 = left end, bit 0 = right end
- winner  output  2  00 = none, 10 = left won, 01 = right won
- busy  output  1  high in START, PLAY and WIN

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. rst asserted forces the following immediately, with no clock edge needed:
  - state = IDLE
  - leds_ctrl = 1
  - score = 7'b0001000 (pos = 3)
  - winner = 00
  - busy = 0
  - tick counter = 0
  - both button-history flops = 1
- Edge detect:
  - press_x = pb_x & ~prev_x; prev_x <= pb_x every cycle.
  - Because history resets to 1, a button held through reset release produces no press.
  - A held button yields exactly one press.
- Latency: outputs change on the same clock edge that first samples a button high.
- Tick generator:
  - Counter runs 0..TICK_DIV-1. tick = (count == TICK_DIV-1).
  - Counter clears on every state transition, so each half-period is exactly TICK_DIV cycles.
- State IDLE:
  - Outputs: leds_ctrl = 1, busy = 0. winner holds its last value.
  - Any press (left, right or both) → START. On the transition: winner <= 00, busy <= 1, leds_ctrl <= 3, half-period count hc <= 0.
- State START:
  - leds_ctrl alternates 3/0, toggling on each tick, starting at 3.
  - After 2*START_FLASHES ticks → PLAY: leds_ctrl <= 2, pos <= 3.
  - Presses are ignored.
- State PLAY: leds_ctrl = 2, score = 1 << pos. Press handling:
  - Left only, pos < 6: pos + 1.
  - Right only, pos > 0: pos − 1.
  - Left only, pos == 6: → WIN, winner <= 10.
  - Right only, pos == 0: → WIN, winner <= 01.
  - Both presses in the same cycle: no change.
  - pos never wraps; its range is 0..6.
- State WIN:
  - score frozen at the winning end.
  - leds_ctrl alternates 3/2, toggling on each tick, starting at 3.
  - After 2*WIN_FLASHES ticks → IDLE: leds_ctrl <= 1, busy <= 0, score <= 7'b0001000. winner is held.
  - Presses are ignored.
- Reset mid-operation (any state): immediate return to reset values. No partial flash completes.
- No illegal leds_ctrl codes. Unused state encodings → IDLE.

Test Plan (TICK_DIV=4, START_FLASHES=2, WIN_FLASHES=2):
1. Assert rst asynchronously between clock edges → outputs immediately read leds_ctrl=1, score=0001000, winner=00, busy=0. Hold pb_l=1 across rst release → no START.
2. From IDLE, pulse pb_l for 1 cycle → busy=1 on that edge. leds_ctrl sequence is 3×4, 0×4, 3×4, 0×4 cycles, then leds_ctrl=2 with score=0001000.
3. In PLAY, send 3 separate pb_l presses → score 0010000, 0100000, 1000000. A 4th press → winner=10, leds_ctrl 3/2 alternating for 16 cycles, then leds_ctrl=1, busy=0, winner stays 10.
4. In PLAY, assert pb_l and pb_r rising in the same cycle → score unchanged. Hold pb_r high for 20 cycles → score moves exactly one step right.
5. In PLAY, drive pos to 0 with pb_r presses (score=0000001), then one more pb_r press → winner=01. Presses during the WIN flash → ignored.
6. Assert rst mid-START and again mid-WIN → immediate return to IDLE values, winner=00. The next press restarts the full START sequence.
